gf_log_seq: RTL and testbench

- Sequential discrete-log unit for GF(2^m). It is the inverse of the alpha-power datapath.
- Given a nonzero field element x, it returns k such that alpha^k = x.
- It steps an accumulator through alpha^0, alpha^1, ... and counts the steps until the accumulator equals x.
- It sits beside mul_alpha in the mul_gf accelerator group and feeds log-domain multiply/divide and decoder error-locator paths.

---
 rtl/gf_pkg.sv | 34 +++
 rtl/gf_alpha_step.sv | 31 +++
 rtl/gf_log_seq.sv | 122 ++++++++++++
 tb/tb_gf_log_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions: default field parameters, the log-unit state
// encoding and the multiply-by-alpha step rule used by gf_alpha_step and mul_alpha.
package gf_pkg;

   localparam int          GF_M     = 4;
   localparam logic [4:0]  GF_POLY  = 5'b10011;
   localparam int          GF_MAX_M = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } gf_state_t;

   // Works on a fixed wide container so any m up to GF_MAX_M shares one body;
   // bits at and above m are masked off and always return as zero.
   function automatic logic [GF_MAX_M-1:0] gf_mul_alpha(
      input logic [GF_MAX_M-1:0] elem,
      input logic [GF_MAX_M:0]   poly,
      input int unsigned         m
   );
      logic [GF_MAX_M-1:0] mask;
      logic [GF_MAX_M-1:0] top;
      logic [GF_MAX_M-1:0] res;
      mask = ~({GF_MAX_M{1'b1}} << m);
      top  = mask ^ (mask >> 1);
      res  = (elem << 1) & mask;
      if (|(elem & top)) begin
         res = res ^ (poly[GF_MAX_M-1:0] & mask);
      end
      return res;
   endfunction

endpackage

// File: rtl/gf_alpha_step.sv
// Combinational multiply-by-alpha in GF(2^M): shift left, fold the carried-out
// MSB back in with the reduction polynomial.
module gf_alpha_step
   import gf_pkg::*;
#(
   parameter int             M    = GF_M,
   parameter logic [M:0]     POLY = GF_POLY
) (
   input  logic [M-1:0] elem,
   output logic [M-1:0] elem_next
);

   localparam int PW = GF_MAX_M + 1;

   logic [GF_MAX_M-1:0] wide_elem;
   logic [GF_MAX_M:0]   wide_poly;
   logic [GF_MAX_M-1:0] wide_res;

   assign wide_elem = GF_MAX_M'(elem);
   assign wide_poly = PW'(POLY);
   assign wide_res  = gf_mul_alpha(wide_elem, wide_poly, M);
   assign elem_next = wide_res[M-1:0];

   generate
      if (M < GF_MAX_M) begin : g_pad
         logic unused_hi;
         assign unused_hi = |wide_res[GF_MAX_M-1:M];
      end
   endgenerate

endmodule

// File: rtl/gf_log_seq.sv
// Sequential discrete log over GF(2^m): walks acc = alpha^cnt from alpha^0 until
// it equals the operand, then returns cnt (or an error when no log exists).
module gf_log_seq
   import gf_pkg::*;
#(
   parameter int               PARAM_M    = GF_M,
   parameter logic [PARAM_M:0] PARAM_POLY = GF_POLY
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PARAM_M-1:0] in_1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PARAM_M-1:0] out_1,
   output logic               out_err,
   output gf_state_t          dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both
   // high; in_ready is high only in IDLE, out_valid only in DONE, and a DONE
   // result is held unchanged until it is taken.

   localparam logic [PARAM_M-1:0] CNT_LAST = {{(PARAM_M-1){1'b1}}, 1'b0};
   localparam logic [PARAM_M-1:0] ONE      = {{(PARAM_M-1){1'b0}}, 1'b1};

   gf_state_t          state, state_d;
   logic [PARAM_M-1:0] x_q;
   logic [PARAM_M-1:0] acc;
   logic [PARAM_M-1:0] acc_next;
   logic [PARAM_M-1:0] cnt;
   logic               x_zero;
   logic               hit;
   logic               exhausted;

   gf_alpha_step #(
      .M    (PARAM_M),
      .POLY (PARAM_POLY)
   ) u_step (
      .elem      (acc),
      .elem_next (acc_next)
   );

   // A zero operand still spends one SEARCH cycle so its latency matches k=0.
   assign x_zero    = (x_q == '0);
   assign hit       = (acc == x_q);
   assign exhausted = (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (x_zero || hit || exhausted) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q     <= '0;
         acc     <= ONE;
         cnt     <= '0;
         out_1   <= '0;
         out_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  x_q <= in_1;
                  acc <= ONE;
                  cnt <= '0;
               end
            end
            ST_SEARCH: begin
               if (x_zero) begin
                  out_1   <= '0;
                  out_err <= 1'b1;
               end else if (hit) begin
                  out_1   <= cnt;
                  out_err <= 1'b0;
               end else if (exhausted) begin
                  out_1   <= '0;
                  out_err <= 1'b1;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_gf_log_seq.sv
// Directed bench for gf_log_seq: one instance on x^4+x+1, one on the
// non-primitive x^4+x^3+x^2+x+1.
module tb_gf_log_seq;
   import gf_pkg::*;

   typedef struct {
      logic [3:0] x;
      logic [3:0] k;
      logic       err;
      int         lat;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic [3:0] in_1      [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [3:0] out_1     [2];
   logic       out_err   [2];
   gf_state_t  dbg_state [2];

   logic [12:0] exp_q[$];
   int          total = 0;
   int          bad   = 0;

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   gf_log_seq #(.PARAM_M(4), .PARAM_POLY(5'b10011)) dut_p (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .in_1      (in_1[0]),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .out_1     (out_1[0]),
      .out_err   (out_err[0]),
      .dbg_state (dbg_state[0])
   );

   gf_log_seq #(.PARAM_M(4), .PARAM_POLY(5'b11111)) dut_n (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .in_1      (in_1[1]),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .out_1     (out_1[1]),
      .out_err   (out_err[1]),
      .dbg_state (dbg_state[1])
   );

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // driver: present x on dut d and leave at the negedge after the accept edge
   task automatic send(input int d, input logic [3:0] x);
      int guard = 0;
      @(negedge clk);
      while (!in_ready[d] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check($sformatf("in_ready_pre d=%0d x=%h", d, x), int'(in_ready[d]), 1);
      in_valid[d] = 1'b1;
      in_1[d]     = x;
      @(posedge clk);
      @(negedge clk);
      in_valid[d] = 1'b0;
      in_1[d]     = 4'($urandom_range(0, 15));
      check($sformatf("in_ready_busy d=%0d x=%h", d, x), int'(in_ready[d]), 0);
   endtask

   task automatic wait_result(input int d, output int lat);
      lat = 0;
      while (!out_valid[d] && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic compare(input int d, input logic [3:0] x, input int lat);
      logic [12:0] e;
      if (exp_q.size() == 0) begin
         check("exp_q_empty", 0, 1);
         return;
      end
      e = exp_q.pop_front();
      check($sformatf("out_valid d=%0d x=%h", d, x), int'(out_valid[d]), 1);
      check($sformatf("out_1 d=%0d x=%h", d, x), int'(out_1[d]), int'(e[12:9]));
      check($sformatf("out_err d=%0d x=%h", d, x), int'(out_err[d]), int'(e[8]));
      check($sformatf("latency d=%0d x=%h", d, x), lat, int'(e[7:0]));
   endtask

   task automatic release_result(input int d);
      out_ready[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[d] = 1'b0;
      check($sformatf("out_valid_drop d=%0d", d), int'(out_valid[d]), 0);
      check($sformatf("in_ready_back d=%0d", d), int'(in_ready[d]), 1);
   endtask

   task automatic run_op(input int d, input logic [3:0] x, input logic [3:0] k,
                         input logic err, input int lat_exp);
      int lat;
      exp_q.push_back({k, err, 8'(lat_exp)});
      send(d, x);
      wait_result(d, lat);
      compare(d, x, lat);
      release_result(d);
   endtask

   initial begin
      vec_t       vecs[16];
      logic [3:0] sweep[14];
      int         lat;

      for (int d = 0; d < 2; d++) begin
         in_valid[d]  = 1'b0;
         in_1[d]      = 4'h0;
         out_ready[d] = 1'b0;
      end

      sweep = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
      vecs[0] = '{x: 4'h1, k: 4'd0, err: 1'b0, lat: 1};
      for (int i = 0; i < 14; i++) begin
         vecs[i+1] = '{x: sweep[i], k: 4'(i + 1), err: 1'b0, lat: i + 2};
      end
      vecs[15] = '{x: 4'h0, k: 4'd0, err: 1'b1, lat: 1};

      // reset state
      #2;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst in_ready d=%0d", d), int'(in_ready[d]), 1);
         check($sformatf("rst out_valid d=%0d", d), int'(out_valid[d]), 0);
         check($sformatf("rst out_1 d=%0d", d), int'(out_1[d]), 0);
         check($sformatf("rst out_err d=%0d", d), int'(out_err[d]), 0);
         check($sformatf("rst state d=%0d", d), int'(dbg_state[d]), int'(ST_IDLE));
      end
      @(negedge clk);
      rst = 1'b0;

      // primitive polynomial: full log table plus zero operand
      for (int i = 0; i < 16; i++) begin
         run_op(0, vecs[i].x, vecs[i].k, vecs[i].err, vecs[i].lat);
      end

      // backpressure with an ignored operand pulse
      exp_q.push_back({4'd8, 1'b0, 8'd9});
      send(0, 4'h5);
      wait_result(0, lat);
      compare(0, 4'h5, lat);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("hold out_valid c=%0d", c), int'(out_valid[0]), 1);
         check($sformatf("hold out_1 c=%0d", c), int'(out_1[0]), 8);
         check($sformatf("hold out_err c=%0d", c), int'(out_err[0]), 0);
         check($sformatf("hold in_ready c=%0d", c), int'(in_ready[0]), 0);
         in_valid[0] = (c == 1 || c == 2);
         in_1[0]     = 4'h3;
         @(negedge clk);
      end
      in_valid[0] = 1'b0;
      release_result(0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("not_queued out_valid c=%0d", c), int'(out_valid[0]), 0);
         check($sformatf("not_queued state c=%0d", c), int'(dbg_state[0]), int'(ST_IDLE));
      end

      // asynchronous reset in the middle of a search
      send(0, 4'h9);
      repeat (5) @(negedge clk);
      check("mid state before rst", int'(dbg_state[0]), int'(ST_SEARCH));
      rst = 1'b1;
      #1;
      check("midrst in_ready", int'(in_ready[0]), 1);
      check("midrst out_valid", int'(out_valid[0]), 0);
      check("midrst out_1", int'(out_1[0]), 0);
      check("midrst out_err", int'(out_err[0]), 0);
      check("midrst state", int'(dbg_state[0]), int'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;
      run_op(0, 4'hB, 4'd7, 1'b0, 8);

      // non-primitive polynomial: short orbit and an unreachable element
      run_op(1, 4'hF, 4'd4, 1'b0, 5);
      run_op(1, 4'h3, 4'd0, 1'b1, 15);
      run_op(1, 4'h8, 4'd3, 1'b0, 4);

      check("exp_q drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
